// File: rtl/gpio_debounce_pkg.sv
// Shared defaults for the GPIO pad debouncer slice.
// Keeps the board-level default timing in one place for the top and channel modules.
package gpio_debounce_pkg;

  localparam int unsigned DEF_N_CHANNELS   = 4;
  localparam int unsigned DEF_TICK_DIV     = 12000;  // 1 ms at 12 MHz
  localparam int unsigned DEF_STABLE_TICKS = 8;

endpackage

// File: rtl/gpio_debounce_channel.sv
// One debounced channel: stability counter, accepted level and edge strobes.
// Acceptance needs STABLE_TICKS consecutive ticks with s differing from db_out.
module gpio_debounce_channel
  import gpio_debounce_pkg::*;
#(
  parameter int unsigned STABLE_TICKS = DEF_STABLE_TICKS,
  parameter logic        RESET_LEVEL  = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic s,
  input  logic tick,
  output logic db_out,
  output logic rise,
  output logic fall
);

  localparam int unsigned CW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
  localparam logic [CW-1:0] CTR_LAST = CW'(STABLE_TICKS - 1);

  logic [CW-1:0] ctr;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctr    <= '0;
      db_out <= RESET_LEVEL;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (s == db_out) begin
        // Any return to the accepted level discards progress, tick or not.
        ctr <= '0;
      end else if (tick) begin
        if (ctr == CTR_LAST) begin
          db_out <= s;
          ctr    <= '0;
          rise   <= s;
          fall   <= ~s;
        end else begin
          ctr <= ctr + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/gpio_debounce.sv
// Synchronises and debounces N raw pad inputs into clean levels plus press/release strobes.
// Shared prescaler sets the sampling rate; each channel filters independently.
module gpio_debounce
  import gpio_debounce_pkg::*;
#(
  parameter int unsigned                N_CHANNELS   = DEF_N_CHANNELS,
  parameter int unsigned                TICK_DIV     = DEF_TICK_DIV,
  parameter int unsigned                STABLE_TICKS = DEF_STABLE_TICKS,
  parameter logic [N_CHANNELS-1:0]      INVERT       = '0,
  parameter logic [N_CHANNELS-1:0]      RESET_LEVEL  = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CHANNELS-1:0] pad_in,
  output logic [N_CHANNELS-1:0] db_out,
  output logic [N_CHANNELS-1:0] rise,
  output logic [N_CHANNELS-1:0] fall
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [N_CHANNELS-1:0] sync1;
  logic [N_CHANNELS-1:0] sync2;
  logic [N_CHANNELS-1:0] s;
  logic                  tick;

  // Synchroniser resets to the pre-invert image of RESET_LEVEL so reset exit
  // sees s == db_out and never starts a spurious acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= RESET_LEVEL ^ INVERT;
      sync2 <= RESET_LEVEL ^ INVERT;
    end else begin
      sync1 <= pad_in;
      sync2 <= sync1;
    end
  end

  assign s = sync2 ^ INVERT;

  generate
    if (TICK_DIV == 1) begin : g_no_div
      assign tick = 1'b1;
    end else begin : g_div
      logic [PW-1:0] count;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    count <= '0;
        else if (tick) count <= '0;
        else           count <= count + 1'b1;
      end

      assign tick = (count == PW'(TICK_DIV - 1));
    end
  endgenerate

  for (genvar i = 0; i < N_CHANNELS; i++) begin : g_ch
    gpio_debounce_channel #(
      .STABLE_TICKS (STABLE_TICKS),
      .RESET_LEVEL  (RESET_LEVEL[i])
    ) u_channel (
      .clk    (clk),
      .rst_n  (rst_n),
      .s      (s[i]),
      .tick   (tick),
      .db_out (db_out[i]),
      .rise   (rise[i]),
      .fall   (fall[i])
    );
  end

endmodule

// File: tb/tb_gpio_debounce.sv
// Directed bench for gpio_debounce: reset, press latency, glitch, bounce, simultaneous edges,
// and async reset mid-count. TICK_DIV=4, STABLE_TICKS=3 -> 9..12 cycles after s changes.
module tb_gpio_debounce;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic [3:0] pad_in = 4'b0000;
  logic [3:0] db_out;
  logic [3:0] rise;
  logic [3:0] fall;

  int checks = 0;
  int errors = 0;
  int rise_cnt [4];
  int fall_cnt [4];
  bit both_seen = 1'b0;
  int n;

  gpio_debounce #(
    .N_CHANNELS   (4),
    .TICK_DIV     (4),
    .STABLE_TICKS (3),
    .INVERT       (4'b0100),
    .RESET_LEVEL  (4'b0000)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .pad_in (pad_in),
    .db_out (db_out),
    .rise   (rise),
    .fall   (fall)
  );

  always #5 clk = ~clk;

  // Strobe monitor: tallies every strobe cycle seen at the falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rise[i] === 1'b1) rise_cnt[i]++;
      if (fall[i] === 1'b1) fall_cnt[i]++;
      if (rise[i] === 1'b1 && fall[i] === 1'b1) both_seen = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance k falling edges, then settle 1 time unit past the edge.
  task automatic step(input int k);
    repeat (k) @(negedge clk);
    #1;
  endtask

  // Count rising clock edges until db_out[ch] reaches val; returns bound+1 on timeout.
  task automatic wait_level(input int ch, input logic val, input int bound, output int cnt);
    cnt = 0;
    while (db_out[ch] !== val && cnt <= bound) begin
      step(1);
      cnt++;
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      rise_cnt[i] = 0;
      fall_cnt[i] = 0;
    end

    // Reset held while pads toggle
    #1;
    repeat (4) begin
      pad_in = ~pad_in;
      step(1);
    end
    check("reset_db_out", 32'(db_out), 32'(4'b0000));
    check("reset_rise",   32'(rise),   32'(4'b0000));
    check("reset_fall",   32'(fall),   32'(4'b0000));

    // Release with inverted channel at its idle level: nothing may change
    pad_in = 4'b0100;
    step(1);
    rst_n = 1'b1;
    step(40);
    check("idle_db_out", 32'(db_out), 32'(4'b0000));
    check("idle_strobes",
          32'(rise_cnt[0] + rise_cnt[1] + rise_cnt[2] + rise_cnt[3]
            + fall_cnt[0] + fall_cnt[1] + fall_cnt[2] + fall_cnt[3]), 32'd0);

    // Clean press on channel 0
    pad_in[0] = 1'b1;
    wait_level(0, 1'b1, 30, n);
    check("press_latency_11_14", 32'(n >= 11 && n <= 14), 32'd1);
    check("press_rise_aligned",  32'(rise[0]), 32'd1);
    check("press_no_fall",       32'(fall[0]), 32'd0);
    step(1);
    check("press_rise_one_cycle", 32'(rise[0]), 32'd0);
    step(20);
    check("press_db_out",   32'(db_out[0]), 32'd1);
    check("press_rise_cnt", 32'(rise_cnt[0]), 32'd1);
    check("press_fall_cnt", 32'(fall_cnt[0]), 32'd0);

    // Glitch on channel 1: 6 cycles high spans at most 2 ticks
    pad_in[1] = 1'b1;
    step(6);
    pad_in[1] = 1'b0;
    step(30);
    check("glitch_db_out",   32'(db_out[1]), 32'd0);
    check("glitch_rise_cnt", 32'(rise_cnt[1]), 32'd0);
    check("glitch_fall_cnt", 32'(fall_cnt[1]), 32'd0);

    // Bounce on inverted channel 2: five toggles, ending held low
    for (int k = 0; k < 5; k++) begin
      pad_in[2] = ~pad_in[2];
      step(3);
    end
    wait_level(2, 1'b1, 40, n);
    check("bounce_accept_in_time", 32'(n <= 40), 32'd1);
    step(20);
    check("bounce_db_out",   32'(db_out[2]), 32'd1);
    check("bounce_rise_cnt", 32'(rise_cnt[2]), 32'd1);
    check("bounce_fall_cnt", 32'(fall_cnt[2]), 32'd0);
    pad_in[2] = 1'b1;
    wait_level(2, 1'b0, 40, n);
    check("release_accept_in_time", 32'(n <= 40), 32'd1);
    step(20);
    check("release_fall_cnt", 32'(fall_cnt[2]), 32'd1);
    check("release_rise_cnt", 32'(rise_cnt[2]), 32'd1);

    // Simultaneous: channel 3 presses while channel 0 releases
    pad_in[3] = 1'b1;
    pad_in[0] = 1'b0;
    wait_level(3, 1'b1, 40, n);
    check("simul_rise3", 32'(rise[3]), 32'd1);
    check("simul_fall0", 32'(fall[0]), 32'd1);
    check("simul_db_out", 32'(db_out), 32'(4'b1000));
    step(20);
    check("simul_rise3_cnt", 32'(rise_cnt[3]), 32'd1);
    check("simul_fall0_cnt", 32'(fall_cnt[0]), 32'd1);

    // Async reset while channel 1 is part-way through its count
    pad_in[1] = 1'b1;
    step(7);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_db_out", 32'(db_out), 32'(4'b0000));
    check("async_rise",   32'(rise),   32'(4'b0000));
    check("async_fall",   32'(fall),   32'(4'b0000));
    step(3);
    rst_n = 1'b1;
    wait_level(1, 1'b1, 30, n);
    check("post_reset_latency_11_14", 32'(n >= 11 && n <= 14), 32'd1);
    check("post_reset_db_out", 32'(db_out), 32'(4'b1010));
    check("post_reset_rise",   32'(rise),   32'(4'b1010));
    step(20);
    check("post_reset_rise1_cnt", 32'(rise_cnt[1]), 32'd1);
    check("post_reset_rise3_cnt", 32'(rise_cnt[3]), 32'd2);
    check("rise_fall_exclusive",  32'(both_seen), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
